// File: rtl/nmos_pkg.sv
// Shared encodings for the two-phase NMOS register library: phase decode and master-source select.
// Optional build macro used by this library: NMOS_DYN_DECAY_EN (dynamic master decay).
package nmos_pkg;

  typedef enum logic [1:0] {
    PH_NONE = 2'b00,
    PH_1    = 2'b01,
    PH_2    = 2'b10,
    PH_OVL  = 2'b11
  } phase_e;

  // On a PHI2 edge SRC_HOLD recirculates the slave, so the pair as a whole holds.
  typedef enum logic [1:0] {
    SRC_HOLD  = 2'b00,
    SRC_LOAD  = 2'b01,
    SRC_SHIFT = 2'b10
  } src_e;

  function automatic phase_e phase_decode(input logic c1, input logic c2);
    return phase_e'({c2, c1});
  endfunction

endpackage

// File: rtl/nmos_phase_ctl.sv
// Phase decode for the NMOS register bank, sticky overlap flag, and optional master-decay timer.
// Build macro NMOS_DYN_DECAY_EN adds the decay counter; all outputs are registered or pure decode.
module nmos_phase_ctl
  import nmos_pkg::*;
#(
  parameter int DECAY_CYCLES = 64
) (
  input  logic main_clk,
  input  logic R,
  input  logic S,
  input  logic C1,
  input  logic C2,
  output logic phi1_en,
  output logic phi2_en,
  output logic ovl_evt,
  output logic ovl,
  output logic decay
);

  phase_e ph;
  logic   ovl_q, ovl_d;

  assign ph      = phase_decode(C1, C2);
  assign phi1_en = (ph == PH_1);
  assign phi2_en = (ph == PH_2);
  assign ovl_evt = (ph == PH_OVL);
  assign ovl     = ovl_q;

  // Set takes priority over the overlap check, so an overlap under S is not flagged.
  always_comb begin
    ovl_d = ovl_q;
    if (!S && ovl_evt) ovl_d = 1'b1;
  end

  always_ff @(posedge main_clk) begin
    if (R) ovl_q <= 1'b0;
    else   ovl_q <= ovl_d;
  end

`ifdef NMOS_DYN_DECAY_EN
  localparam int CNT_W = $clog2(DECAY_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DECAY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mst_wr;

  assign mst_wr = S || phi2_en;
  // Decay fires on the edge the counter reaches the limit, so a following PHI1 sees zeros.
  assign decay  = !mst_wr && (cnt_q >= CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (mst_wr)               cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge main_clk) begin
    if (R) cnt_q <= '0;
    else   cnt_q <= cnt_d;
  end
`else
  // DECAY_CYCLES is constrained to >= 1, so this is constantly zero: the master never decays.
  assign decay = (DECAY_CYCLES < 1);
`endif

endmodule

// File: rtl/nmos_dff_bank.sv
// Two-phase NMOS master/slave bank: PHI2 samples master (load/shift/recirculate), PHI1 copies to slave.
// Sync active-high R, then S, overlap flag; Q/Q_n/SO combinational from slave; optional NMOS_DYN_DECAY_EN.
module nmos_dff_bank
  import nmos_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] SET_VAL      = {WIDTH{1'b1}},
  parameter int               DECAY_CYCLES = 64
) (
  input  logic             main_clk,
  input  logic             R,
  input  logic             C1,
  input  logic             C2,
  input  logic             S,
  input  logic             LD,
  input  logic             SH,
  input  logic             SI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n,
  output logic             SO,
  output logic             OVL
);

  logic [WIDTH-1:0] mst_q, mst_d;
  logic [WIDTH-1:0] slv_q, slv_d;
  logic [WIDTH-1:0] shift_val;
  logic             phi1_en, phi2_en, ovl_evt, decay;
  src_e             src;

  nmos_phase_ctl #(
    .DECAY_CYCLES(DECAY_CYCLES)
  ) u_phase_ctl (
    .main_clk(main_clk),
    .R       (R),
    .S       (S),
    .C1      (C1),
    .C2      (C2),
    .phi1_en (phi1_en),
    .phi2_en (phi2_en),
    .ovl_evt (ovl_evt),
    .ovl     (OVL),
    .decay   (decay)
  );

  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign shift_val = SI;
    end else begin : g_shift_wn
      assign shift_val = {slv_q[WIDTH-2:0], SI};
    end
  endgenerate

  assign src = LD ? SRC_LOAD : (SH ? SRC_SHIFT : SRC_HOLD);

  always_comb begin
    mst_d = mst_q;
    slv_d = slv_q;
    if (S) begin
      mst_d = SET_VAL;
      slv_d = SET_VAL;
    end else if (phi2_en) begin
      case (src)
        SRC_LOAD:  mst_d = D;
        SRC_SHIFT: mst_d = shift_val;
        default:   mst_d = slv_q;
      endcase
    end else if (!ovl_evt) begin
      if (phi1_en) slv_d = mst_q;
      if (decay)   mst_d = '0;
    end else begin
      if (decay)   mst_d = '0;
    end
  end

  always_ff @(posedge main_clk) begin
    if (R) begin
      mst_q <= '0;
      slv_q <= '0;
    end else begin
      mst_q <= mst_d;
      slv_q <= slv_d;
    end
  end

  assign Q   = slv_q;
  assign Q_n = ~slv_q;
  assign SO  = slv_q[WIDTH-1];

endmodule

// File: tb/tb_nmos_dff_bank.sv
// Directed test of nmos_dff_bank: reset, load, shift, set/reset priority, overlap, idempotence, decay.
module tb_nmos_dff_bank;

  logic       main_clk = 1'b0;
  logic       R = 1'b0, C1 = 1'b0, C2 = 1'b0, S = 1'b0, LD = 1'b0, SH = 1'b0, SI = 1'b0;
  logic [7:0] D = 8'h00;
  logic [7:0] Q, Q_n;
  logic       SO, OVL;

  int errors = 0;
  int checks = 0;

  nmos_dff_bank #(
    .WIDTH       (8),
    .SET_VAL     (8'hA5),
    .DECAY_CYCLES(4)
  ) dut (
    .main_clk(main_clk),
    .R       (R),
    .C1      (C1),
    .C2      (C2),
    .S       (S),
    .LD      (LD),
    .SH      (SH),
    .SI      (SI),
    .D       (D),
    .Q       (Q),
    .Q_n     (Q_n),
    .SO      (SO),
    .OVL     (OVL)
  );

  always #5 main_clk = ~main_clk;

  // Drive one edge's worth of inputs, clock it, then sample 1 time unit later.
  task automatic step(input logic r, input logic s, input logic c1, input logic c2,
                      input logic ld, input logic sh, input logic si, input logic [7:0] d);
    R = r; S = s; C1 = c1; C2 = c2; LD = ld; SH = sh; SI = si; D = d;
    @(posedge main_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0] decay_exp;

    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 8'h00);
    chk("rst_q",   Q, 8'h00);
    chk("rst_qn",  Q_n, 8'hFF);
    chk("rst_so",  {7'd0, SO}, 8'h00);
    chk("rst_ovl", {7'd0, OVL}, 8'h00);

    // Load 3C: not visible until PHI1
    step(0, 0, 0, 1, 1, 0, 0, 8'h3C);
    chk("load_pre_c1", Q, 8'h00);
    step(0, 0, 1, 0, 0, 0, 0, 8'h00);
    chk("load_q",  Q, 8'h3C);
    chk("load_qn", Q_n, 8'hC3);

    // Load 81 then shift SI=0, then SI=1
    step(0, 0, 0, 1, 1, 0, 0, 8'h81);
    step(0, 0, 1, 0, 0, 0, 0, 8'h00);
    chk("load81_q",  Q, 8'h81);
    chk("load81_so", {7'd0, SO}, 8'h01);
    step(0, 0, 0, 1, 0, 1, 0, 8'h00);
    step(0, 0, 1, 0, 0, 1, 0, 8'h00);
    chk("shift1_q",  Q, 8'h02);
    chk("shift1_so", {7'd0, SO}, 8'h00);
    step(0, 0, 0, 1, 0, 1, 1, 8'h00);
    step(0, 0, 1, 0, 0, 1, 1, 8'h00);
    chk("shift2_q", Q, 8'h05);

    // LD beats SH
    step(0, 0, 0, 1, 1, 1, 1, 8'h11);
    // Set mid-pair overrides the C1 on the same edge
    step(0, 1, 1, 0, 0, 0, 0, 8'h00);
    chk("set_mid_q", Q, 8'hA5);
    step(0, 0, 1, 0, 0, 0, 0, 8'h00);
    chk("set_rel_c1_q", Q, 8'hA5);
    step(1, 1, 0, 0, 0, 0, 0, 8'h00);
    chk("rs_both_q", Q, 8'h00);

    // Overlap holds both latches and flags OVL
    step(0, 0, 0, 1, 1, 0, 0, 8'h12);
    step(0, 0, 1, 0, 0, 0, 0, 8'h00);
    chk("pre_ovl_q", Q, 8'h12);
    step(0, 0, 1, 1, 1, 0, 0, 8'hFF);
    chk("ovl_q",   Q, 8'h12);
    chk("ovl_flag", {7'd0, OVL}, 8'h01);
    step(0, 0, 1, 0, 0, 0, 0, 8'h00);
    chk("ovl_master_held", Q, 8'h12);
    step(0, 1, 0, 0, 0, 0, 0, 8'h00);
    chk("set_keeps_ovl", {7'd0, OVL}, 8'h01);
    chk("set_q", Q, 8'hA5);
    step(1, 0, 0, 0, 0, 0, 0, 8'h00);
    chk("rst_clears_ovl", {7'd0, OVL}, 8'h00);

    // Repeated PHI2 is idempotent: one shift only
    step(0, 0, 0, 1, 1, 0, 0, 8'h01);
    step(0, 0, 1, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 1, 0, 1, 1, 8'h00);
    step(0, 0, 0, 1, 0, 1, 1, 8'h00);
    step(0, 0, 0, 1, 0, 1, 1, 8'h00);
    chk("idem_pre_c1", Q, 8'h01);
    step(0, 0, 1, 0, 0, 0, 0, 8'h00);
    chk("idem_q", Q, 8'h03);
    step(0, 0, 1, 0, 0, 0, 0, 8'h00);
    chk("idem_c1_again", Q, 8'h03);

    // Load 5A, idle 4 edges, then PHI1
    step(0, 0, 0, 1, 1, 0, 0, 8'h5A);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 0, 0, 0, 8'h00);
`ifdef NMOS_DYN_DECAY_EN
    decay_exp = 8'h00;
`else
    decay_exp = 8'h5A;
`endif
    chk("decay_q", Q, decay_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
